// File: rtl/mcec_pkg.sv
// Shared constants and types for the multi-channel event counter.
// Holds the default parameter values, the per-channel state layout at the
// default widths, and the select-width helper used by the top.
// Optional build macro: CNT_SAT_EN (saturating counters instead of wrapping).
package mcec_pkg;

  localparam int unsigned NCH_DEF     = 2;
  localparam int unsigned W_DEF       = 64;
  localparam int unsigned PW_DEF      = 8;
  localparam int unsigned DIV_RST_DEF = 0;

  // Per-channel architectural state at the default widths.
  typedef struct packed {
    logic [PW_DEF-1:0] div;
    logic [PW_DEF-1:0] pre;
    logic [W_DEF-1:0]  cnt;
    logic              ovf;
  } chan_state_t;

  // Channel-select width, never narrower than one bit.
  function automatic int unsigned sel_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mcec_chan.sv
// One channel of the event counter: runtime divisor, prescaler, counter and
// sticky overflow flag. Strobes arrive already decoded for this channel.
// Build macro CNT_SAT_EN: counter saturates at all-ones instead of wrapping.
// Ports:
//   Clk      clock, all state on posedge
//   Reset    synchronous active-high reset
//   hit      count enable steered to this channel
//   clr      clear cnt/pre/ovf (highest priority after Reset)
//   cfg      load cfg_div into the divisor and restart the prescaler
//   cfg_div  new divisor D (one increment per D+1 hits)
//   cnt      registered count
//   ovf      registered sticky overflow flag
module mcec_chan #(
  parameter int unsigned W       = 64,
  parameter int unsigned PW      = 8,
  parameter int unsigned DIV_RST = 0
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          hit,
  input  logic          clr,
  input  logic          cfg,
  input  logic [PW-1:0] cfg_div,
  output logic [W-1:0]  cnt,
  output logic          ovf
);

  localparam logic [W-1:0] CNT_MAX = '1;

  logic [PW-1:0] div;
  logic [PW-1:0] pre;

  // Clear beats configure beats count; a blocked hit is simply dropped.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      div <= PW'(DIV_RST);
      pre <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (clr) begin
      pre <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (cfg) begin
      div <= cfg_div;
      pre <= '0;
    end else if (hit) begin
      if (pre == div) begin
        pre <= '0;
        if (cnt == CNT_MAX) begin
          ovf <= 1'b1;
`ifdef CNT_SAT_EN
          cnt <= CNT_MAX;
`else
          cnt <= '0;
`endif
        end else begin
          cnt <= cnt + W'(1);
        end
      end else begin
        pre <= pre + PW'(1);
      end
    end
  end

endmodule

// File: rtl/multi_chan_event_counter.sv
// N-channel event counter with per-channel programmable prescaler, per-channel
// clear and sticky overflow. Each cycle En/Clr are steered to channel Sel and
// CfgWe to channel CfgSel; out-of-range selects touch no channel.
// Build macro CNT_SAT_EN: counters saturate instead of wrapping.
// Ports:
//   Clk     clock
//   Reset   synchronous active-high reset, all channels
//   En      count enable for channel Sel
//   Sel     channel for En / Clr
//   Clr     clear channel Sel
//   CfgWe   write CfgDiv into channel CfgSel's divisor
//   CfgSel  channel for CfgWe
//   CfgDiv  divisor value
//   Count   channel k count at [k*W +: W], registered
//   Ovf     per-channel sticky overflow, registered
module multi_chan_event_counter
  import mcec_pkg::*;
#(
  parameter  int unsigned NCH     = NCH_DEF,
  parameter  int unsigned W       = W_DEF,
  parameter  int unsigned PW      = PW_DEF,
  parameter  int unsigned DIV_RST = DIV_RST_DEF,
  localparam int unsigned SELW    = sel_width(NCH)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             En,
  input  logic [SELW-1:0]  Sel,
  input  logic             Clr,
  input  logic             CfgWe,
  input  logic [SELW-1:0]  CfgSel,
  input  logic [PW-1:0]    CfgDiv,
  output logic [NCH*W-1:0] Count,
  output logic [NCH-1:0]   Ovf
);

  for (genvar k = 0; k < NCH; k++) begin : g_chan
    logic hit;
    logic clr;
    logic cfg;

    // Select decode; values >= NCH match no channel.
    assign hit = En    && (Sel    == SELW'(k));
    assign clr = Clr   && (Sel    == SELW'(k));
    assign cfg = CfgWe && (CfgSel == SELW'(k));

    mcec_chan #(
      .W       (W),
      .PW      (PW),
      .DIV_RST (DIV_RST)
    ) u_chan (
      .Clk     (Clk),
      .Reset   (Reset),
      .hit     (hit),
      .clr     (clr),
      .cfg     (cfg),
      .cfg_div (CfgDiv),
      .cnt     (Count[k*W +: W]),
      .ovf     (Ovf[k])
    );
  end

endmodule

// File: tb/tb_multi_chan_event_counter.sv
// Self-checking bench for multi_chan_event_counter: directed scenarios plus
// random traffic, compared against a behavioural per-channel model.
module tb_multi_chan_event_counter;

  localparam int unsigned NCH     = 3;
  localparam int unsigned W       = 4;
  localparam int unsigned PW      = 4;
  localparam int unsigned DIV_RST = 0;
  localparam int unsigned SELW    = 2;
  localparam int          CMOD    = 16;

  logic             Clk;
  logic             Reset;
  logic             En;
  logic [SELW-1:0]  Sel;
  logic             Clr;
  logic             CfgWe;
  logic [SELW-1:0]  CfgSel;
  logic [PW-1:0]    CfgDiv;
  logic [NCH*W-1:0] Count;
  logic [NCH-1:0]   Ovf;

  int n_assert = 0;
  int n_fail   = 0;

  int m_div [NCH];
  int m_pre [NCH];
  int m_cnt [NCH];
  int m_ovf [NCH];

  multi_chan_event_counter #(
    .NCH(NCH), .W(W), .PW(PW), .DIV_RST(DIV_RST)
  ) dut (
    .Clk(Clk), .Reset(Reset), .En(En), .Sel(Sel), .Clr(Clr),
    .CfgWe(CfgWe), .CfgSel(CfgSel), .CfgDiv(CfgDiv),
    .Count(Count), .Ovf(Ovf)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] dut_cnt(input int k);
    return 32'(Count[k*W +: W]);
  endfunction

  // Reference: one steered tally per channel, counting every (div+1)th hit.
  function automatic void model_step(input logic rst, input logic en, input int sel,
                                     input logic clr, input logic cfgwe, input int cfgsel,
                                     input int cfgdiv);
    for (int k = 0; k < NCH; k++) begin
      if (rst) begin
        m_div[k] = DIV_RST; m_pre[k] = 0; m_cnt[k] = 0; m_ovf[k] = 0;
      end else if (clr && sel == k) begin
        m_pre[k] = 0; m_cnt[k] = 0; m_ovf[k] = 0;
      end else if (cfgwe && cfgsel == k) begin
        m_div[k] = cfgdiv; m_pre[k] = 0;
      end else if (en && sel == k) begin
        if (m_pre[k] < m_div[k]) begin
          m_pre[k]++;
        end else begin
          m_pre[k] = 0;
          if (m_cnt[k] + 1 >= CMOD) begin
            m_ovf[k] = 1;
`ifdef CNT_SAT_EN
            m_cnt[k] = CMOD - 1;
`else
            m_cnt[k] = 0;
`endif
          end else begin
            m_cnt[k]++;
          end
        end
      end
    end
  endfunction

  task automatic check_model(input string tag);
    for (int k = 0; k < NCH; k++) begin
      check($sformatf("%s.cnt%0d", tag, k), dut_cnt(k), 32'(m_cnt[k]));
      check($sformatf("%s.ovf%0d", tag, k), 32'(Ovf[k]), 32'(m_ovf[k]));
    end
  endtask

  // Apply one cycle of inputs, advance the model, check after the edge.
  task automatic cyc(input logic rst, input logic en, input int sel, input logic clr,
                     input logic cfgwe, input int cfgsel, input int cfgdiv);
    Reset  = rst;
    En     = en;
    Sel    = SELW'(sel);
    Clr    = clr;
    CfgWe  = cfgwe;
    CfgSel = SELW'(cfgsel);
    CfgDiv = PW'(cfgdiv);
    @(posedge Clk);
    model_step(rst, en, sel, clr, cfgwe, cfgsel, cfgdiv);
    #1;
    check_model("step");
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 0, 1'b0, 1'b0, 0, 0);
  endtask

  initial begin
    Reset = 1'b1; En = 1'b0; Sel = '0; Clr = 1'b0;
    CfgWe = 1'b0; CfgSel = '0; CfgDiv = '0;

    // Reset state
    cyc(1'b1, 1'b0, 0, 1'b0, 1'b0, 0, 0);
    cyc(1'b1, 1'b0, 0, 1'b0, 1'b0, 0, 0);
    check("rst.cnt0", dut_cnt(0), 32'd0);
    check("rst.ovf", 32'(Ovf), 32'd0);

    // Five steered cycles on channel 0 with D=0
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 0, 1'b0, 1'b0, 0, 0);
    check("d0.cnt0", dut_cnt(0), 32'd5);
    check("d0.cnt1", dut_cnt(1), 32'd0);
    check("d0.cnt2", dut_cnt(2), 32'd0);

    // D=3 on channel 1: increments on 4th and 8th steered cycles
    cyc(1'b0, 1'b0, 0, 1'b0, 1'b1, 1, 3);
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 1, 1'b0, 1'b0, 0, 0);
    check("d3.after8", dut_cnt(1), 32'd2);
    for (int i = 0; i < 2; i++) cyc(1'b0, 1'b1, 1, 1'b0, 1'b0, 0, 0);
    check("d3.after10", dut_cnt(1), 32'd2);

    // Clr wins over En on the same channel
    cyc(1'b0, 1'b1, 0, 1'b1, 1'b0, 0, 0);
    check("clr.cnt0", dut_cnt(0), 32'd0);
    cyc(1'b0, 1'b1, 0, 1'b0, 1'b0, 0, 0);
    check("clr.next", dut_cnt(0), 32'd1);

    // Clr on channel 1 and CfgWe on channel 2 in the same cycle
    cyc(1'b0, 1'b0, 1, 1'b1, 1'b1, 2, 1);
    check("clrcfg.cnt1", dut_cnt(1), 32'd0);
    cyc(1'b0, 1'b1, 2, 1'b0, 1'b0, 0, 0);
    check("clrcfg.cnt2a", dut_cnt(2), 32'd0);
    cyc(1'b0, 1'b1, 2, 1'b0, 1'b0, 0, 0);
    check("clrcfg.cnt2b", dut_cnt(2), 32'd1);

    // Overflow on channel 0 after 16 increments from zero
    cyc(1'b0, 1'b0, 0, 1'b1, 1'b0, 0, 0);
    for (int i = 0; i < 16; i++) cyc(1'b0, 1'b1, 0, 1'b0, 1'b0, 0, 0);
`ifdef CNT_SAT_EN
    check("ovf.cnt0", dut_cnt(0), 32'd15);
`else
    check("ovf.cnt0", dut_cnt(0), 32'd0);
`endif
    check("ovf.flag0", 32'(Ovf[0]), 32'd1);
    cyc(1'b0, 1'b1, 0, 1'b0, 1'b0, 0, 0);
    check("ovf.sticky", 32'(Ovf[0]), 32'd1);

    // Out-of-range select: nothing moves
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 3, 1'b1, 1'b1, 3, 5);
    check("oor.cnt2", dut_cnt(2), 32'd1);

    // Reset mid-prescale: channel 1 at div=3, pre=2
    cyc(1'b0, 1'b0, 0, 1'b0, 1'b1, 1, 3);
    cyc(1'b0, 1'b1, 1, 1'b0, 1'b0, 0, 0);
    cyc(1'b0, 1'b1, 1, 1'b0, 1'b0, 0, 0);
    cyc(1'b1, 1'b1, 1, 1'b0, 1'b0, 0, 0);
    check("rst2.count", 32'(Count), 32'd0);
    check("rst2.ovf", 32'(Ovf), 32'd0);
    cyc(1'b0, 1'b1, 1, 1'b0, 1'b0, 0, 0);
    check("rst2.divrst", dut_cnt(1), 32'd1);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 99) == 0),
          ($urandom_range(0, 3) != 0),
          int'($urandom_range(0, 3)),
          ($urandom_range(0, 19) == 0),
          ($urandom_range(0, 9) == 0),
          int'($urandom_range(0, 3)),
          int'($urandom_range(0, 3)));
    end
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
